mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 95 +++++++++
 tb/tb_mem_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX/MEM register, stall-safe SRAM read buffering, load extraction.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 80,
   parameter int MEM_TO_WB_WD = 70,
   parameter int StallBus     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [StallBus-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [64:0]             ex_to_mem_hilo,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [37:0]             mem_to_id,
   output logic [64:0]             mem_to_wb_hilo
);

   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
   logic [64:0]             hilo_r;
   logic [31:0]             rdata_buf;
   logic                    rdata_vld;

   logic        bubble, advance;
   logic [3:0]  mem_op;
   logic [31:0] pc, ex_result, word, load_data, rf_wdata;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [4:0]  rf_waddr;
   logic        sel_rf_res, rf_we, is_load;
   logic        unused_ok;

   assign bubble  = stall[3] && !stall[4];
   assign advance = !stall[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_to_mem_bus_r <= '0;
         hilo_r          <= '0;
         rdata_buf       <= '0;
         rdata_vld       <= 1'b0;
      end else if (bubble) begin
         ex_to_mem_bus_r <= '0;
         hilo_r          <= '0;
         rdata_vld       <= 1'b0;
      end else if (advance) begin
         ex_to_mem_bus_r <= ex_to_mem_bus;
         hilo_r          <= ex_to_mem_hilo;
         rdata_vld       <= 1'b0;
      end else if (!rdata_vld) begin
         // The SRAM word is only valid in the first MEM cycle; keep it across a hold.
         rdata_buf <= data_sram_rdata;
         rdata_vld <= 1'b1;
      end
   end

   assign mem_op     = ex_to_mem_bus_r[79:76];
   assign pc         = ex_to_mem_bus_r[75:44];
   assign sel_rf_res = ex_to_mem_bus_r[38];
   assign rf_we      = ex_to_mem_bus_r[37];
   assign rf_waddr   = ex_to_mem_bus_r[36:32];
   assign ex_result  = ex_to_mem_bus_r[31:0];
   assign unused_ok  = ^{ex_to_mem_bus_r[43:39], stall[StallBus-1:5], stall[2:0]};

   assign word   = rdata_vld ? rdata_buf : data_sram_rdata;
   assign half_v = ex_result[1] ? word[31:16] : word[15:0];

   always_comb begin
      byte_v = word[7:0];
      case (ex_result[1:0])
         2'b01:   byte_v = word[15:8];
         2'b10:   byte_v = word[23:16];
         2'b11:   byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
   end

   always_comb begin
      is_load   = 1'b1;
      load_data = word;
      case (mem_op)
         4'b1111: load_data = word;
         4'b0001: load_data = {{24{byte_v[7]}}, byte_v};
         4'b0010: load_data = {24'd0, byte_v};
         4'b0011: load_data = {{16{half_v[15]}}, half_v};
         4'b0100: load_data = {16'd0, half_v};
         default: is_load   = 1'b0;
      endcase
   end

   assign rf_wdata       = (sel_rf_res && is_load) ? load_data : ex_result;
   assign mem_to_wb_bus  = {pc, rf_we, rf_waddr, rf_wdata};
   assign mem_to_id      = {rf_we, rf_waddr, rf_wdata};
   assign mem_to_wb_hilo = hilo_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a behavioural reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [79:0] ex_bus;
   logic [64:0] ex_hilo;
   logic [31:0] sram;
   logic [69:0] wb_bus;
   logic [37:0] to_id;
   logic [64:0] wb_hilo;

   int vectors = 0;
   int errors  = 0;

   // Reference model: the instruction currently in MEM and the word captured while held.
   logic [79:0] m_bus;
   logic [64:0] m_hilo;
   logic [31:0] cap_q[$];

   mem_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_to_mem_bus(ex_bus),
      .ex_to_mem_hilo(ex_hilo), .data_sram_rdata(sram),
      .mem_to_wb_bus(wb_bus), .mem_to_id(to_id), .mem_to_wb_hilo(wb_hilo)
   );

   always #5 clk = ~clk;

   function automatic logic [79:0] mk(input logic [3:0] op, input logic [31:0] pc, input logic sel,
                                      input logic we, input logic [4:0] wa, input logic [31:0] res);
      logic [4:0] ramf;
      ramf = 5'($urandom);
      return {op, pc, ramf, sel, we, wa, res};
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic sel,
                                             input logic [31:0] res, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * res[1:0])) & 32'hFF;
      h = (w >> (16 * res[1])) & 32'hFFFF;
      if (!sel) return res;
      case (op)
         4'hF:    return w;
         4'h1:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
         4'h2:    return b;
         4'h3:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         4'h4:    return h;
         default: return res;
      endcase
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_bus  = '0;
      m_hilo = '0;
      cap_q.delete();
   endtask

   task automatic model_edge();
      if (stall[3] && !stall[4]) begin
         model_clear();
      end else if (!stall[3]) begin
         m_bus  = ex_bus;
         m_hilo = ex_hilo;
         cap_q.delete();
      end else if (cap_q.size() == 0) begin
         cap_q.push_back(sram);
      end
   endtask

   task automatic check_all();
      logic [31:0] w, wd;
      w  = (cap_q.size() != 0) ? cap_q[0] : sram;
      wd = ref_wdata(m_bus[79:76], m_bus[38], m_bus[31:0], w);
      check("wb_bus",  128'(wb_bus),  128'({m_bus[75:44], m_bus[37], m_bus[36:32], wd}));
      check("to_id",   128'(to_id),   128'({m_bus[37], m_bus[36:32], wd}));
      check("wb_hilo", 128'(wb_hilo), 128'(m_hilo));
   endtask

   task automatic cycle(input logic [5:0] st, input logic [79:0] b, input logic [64:0] h,
                        input logic [31:0] sram_next);
      stall   = st;
      ex_bus  = b;
      ex_hilo = h;
      @(posedge clk);
      model_edge();
      #1 sram = sram_next;
      #1 check_all();
   endtask

   localparam logic [5:0] RUN  = 6'b000000;
   localparam logic [5:0] HOLD = 6'b011000;
   localparam logic [5:0] BUBL = 6'b001000;

   initial begin
      logic [3:0] ops [10];
      logic [5:0] st;
      ops = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h0, 4'h6, 4'h8};
      rst = 1'b1; stall = '0; ex_bus = '0; ex_hilo = '0; sram = 32'hCAFEF00D;
      model_clear();
      #2;
      check("reset_wb_bus", 128'(wb_bus), 128'd0);
      check("reset_to_id", 128'(to_id), 128'd0);
      check("reset_hilo", 128'(wb_hilo), 128'd0);
      #10 rst = 1'b0;

      cycle(RUN, mk(4'h1, 32'h100, 1, 1, 5'd3, 32'h1003), 65'd0, 32'h80FF1234);
      check("lb_data", 128'(wb_bus[31:0]), 128'(32'hFFFFFF80));
      check("lb_we", 128'(to_id[37]), 128'd1);
      cycle(RUN, mk(4'h4, 32'h104, 1, 1, 5'd4, 32'h1002), 65'd0, 32'h80FF1234);
      check("lhu_data", 128'(wb_bus[31:0]), 128'(32'h000080FF));
      cycle(RUN, mk(4'h3, 32'h108, 1, 1, 5'd5, 32'h1002), 65'd0, 32'h80FF1234);
      check("lh_data", 128'(wb_bus[31:0]), 128'(32'hFFFF80FF));
      cycle(RUN, mk(4'h5, 32'h10C, 1, 1, 5'd6, 32'h1001), 65'd0, 32'h80FF1234);
      check("sb_passthru", 128'(wb_bus[31:0]), 128'(32'h1001));

      cycle(RUN, mk(4'hF, 32'h110, 1, 1, 5'd7, 32'h2000), 65'd0, 32'h11111111);
      check("lw_first", 128'(wb_bus[31:0]), 128'(32'h11111111));
      for (int i = 0; i < 3; i++) begin
         cycle(HOLD, mk(4'h0, 32'hBAD, 0, 1, 5'd9, $urandom), 65'd0, 32'hDEADBEEF);
         check("lw_held", 128'(wb_bus[31:0]), 128'(32'h11111111));
      end

      cycle(BUBL, mk(4'hF, 32'h114, 1, 1, 5'd8, 32'h3000), {1'b1, 64'h1234}, $urandom);
      check("bubble_bus", 128'(wb_bus), 128'd0);
      check("bubble_we", 128'(to_id[37]), 128'd0);
      check("bubble_hilo_we", 128'(wb_hilo[64]), 128'd0);

      cycle(RUN, mk(4'h0, 32'h118, 0, 1, 5'd10, 32'h12345678),
            {1'b1, 32'hAAAA0000, 32'h0000BBBB}, $urandom);
      check("alu_data", 128'(wb_bus[31:0]), 128'(32'h12345678));
      check("alu_hilo", 128'(wb_hilo), 128'({1'b1, 32'hAAAA0000, 32'h0000BBBB}));

      cycle(RUN, mk(4'hF, 32'h11C, 1, 1, 5'd11, 32'h4000), {1'b1, 64'h55}, 32'h11111111);
      cycle(HOLD, '0, '0, 32'hDEADBEEF);
      #1 rst = 1'b1;
      model_clear();
      #1;
      check("async_rst_bus", 128'(wb_bus), 128'd0);
      check("async_rst_id", 128'(to_id), 128'd0);
      check("async_rst_hilo", 128'(wb_hilo), 128'd0);
      rst = 1'b0;
      cycle(RUN, mk(4'hF, 32'h120, 1, 1, 5'd12, 32'h5000), '0, 32'h5A5A5A5A);
      check("post_rst_live", 128'(wb_bus[31:0]), 128'(32'h5A5A5A5A));
      cycle(HOLD, '0, '0, 32'h0F0F0F0F);
      check("post_rst_buf", 128'(wb_bus[31:0]), 128'(32'h5A5A5A5A));

      for (int i = 0; i < 400; i++) begin
         st = 6'($urandom);
         st[3] = ($urandom_range(0, 2) == 0);
         st[4] = ($urandom_range(0, 2) != 0);
         cycle(st, mk(ops[$urandom_range(0, 9)], $urandom, 1'($urandom_range(0, 3) != 0),
                      1'($urandom), 5'($urandom), $urandom),
               {1'($urandom), $urandom, $urandom}, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
